// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, counter types and decode helpers.
package vga_timing_pkg;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ANIM_W = 8;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FP      = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BP      = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FP      = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BP      = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows, measured from the start of the visible region.
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ANIM_W-1:0] anim_t;

    // Inclusive range test used by the sync decodes.
    function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing generator and the drawing stages.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic  anim_en;
    logic  hs;
    logic  vs;
    logic  blank;
    cnt_t  DrawX;
    cnt_t  DrawY;
    logic  line_tick;
    logic  frame_tick;
    anim_t anim_frame;

    modport master (
        input  anim_en,
        output hs, vs, blank, DrawX, DrawY, line_tick, frame_tick, anim_frame
    );

    modport slave (
        output anim_en,
        input  hs, vs, blank, DrawX, DrawY, line_tick, frame_tick, anim_frame
    );

endinterface

// File: rtl/vga_anim_counter.sv
// Frame-divided animation index: steps once every ANIM_DIV enabled frame ticks.
module vga_anim_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ANIM_DIV    = 6,
    parameter int unsigned ANIM_FRAMES = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick,
    input  logic  en,
    output anim_t anim_frame
);

    localparam anim_t DIV_LAST   = anim_t'(ANIM_DIV - 1);
    localparam anim_t FRAME_LAST = anim_t'(ANIM_FRAMES - 1);

    anim_t div_cnt_q, div_cnt_d;
    anim_t anim_frame_q, anim_frame_d;

    // Next-state: divide enabled frame ticks, then wrap the animation index; reset wins.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        anim_frame_d = anim_frame_q;
        if (tick && en) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d    = '0;
                anim_frame_d = (anim_frame_q == FRAME_LAST) ? '0 : anim_frame_q + 8'd1;
            end else begin
                div_cnt_d = div_cnt_q + 8'd1;
            end
        end
        if (reset) begin
            div_cnt_d    = '0;
            anim_frame_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        div_cnt_q    <= div_cnt_d;
        anim_frame_q <= anim_frame_d;
    end

    assign anim_frame = anim_frame_q;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters with sync/blank decodes, line/frame strobes and animation index.
module vga_timing_gen #(
    parameter int unsigned H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int unsigned V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int unsigned ANIM_DIV    = 6,
    parameter int unsigned ANIM_FRAMES = 4
) (
    input  logic            vga_clk,
    input  logic            reset,
    vga_timing_if.master    vga
);
    import vga_timing_pkg::*;

    localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS     = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS     = cnt_t'(V_VISIBLE);
    localparam cnt_t H_SYNC_LO = cnt_t'(H_SYNC_START);
    localparam cnt_t H_SYNC_HI = cnt_t'(H_SYNC_END);
    localparam cnt_t V_SYNC_LO = cnt_t'(V_SYNC_START);
    localparam cnt_t V_SYNC_HI = cnt_t'(V_SYNC_END);

    cnt_t hc_q, hc_d;
    cnt_t vc_q, vc_d;
    logic line_end;
    logic frame_end;

    // Next-state: hc free-runs, vc advances only when hc wraps; reset returns to (0,0).
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
        end
        if (reset) begin
            hc_d = '0;
            vc_d = '0;
        end
    end

    // Counter registers.
    always_ff @(posedge vga_clk) begin
        hc_q <= hc_d;
        vc_q <= vc_d;
    end

    // Decodes are taken straight off the counters so they line up with DrawX/DrawY.
    assign line_end  = (hc_q == H_LAST);
    assign frame_end = line_end && (vc_q == V_LAST);

    assign vga.DrawX      = hc_q;
    assign vga.DrawY      = vc_q;
    assign vga.blank      = (hc_q < H_VIS) && (vc_q < V_VIS);
    assign vga.hs         = ~in_range(hc_q, H_SYNC_LO, H_SYNC_HI);
    assign vga.vs         = ~in_range(vc_q, V_SYNC_LO, V_SYNC_HI);
    assign vga.line_tick  = line_end;
    assign vga.frame_tick = frame_end;

    vga_anim_counter #(
        .ANIM_DIV    (ANIM_DIV),
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_anim (
        .clk        (vga_clk),
        .reset      (reset),
        .tick       (frame_end),
        .en         (vga.anim_en),
        .anim_frame (vga.anim_frame)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size DUT for line timing, short-line DUT for frame/animation timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #20 clk = ~clk;

    vga_timing_if va();
    vga_timing_if vb();

    vga_timing_gen u_dut_a (
        .vga_clk (clk),
        .reset   (rst_a),
        .vga     (va.master)
    );

    // 4-pixel lines keep the 525-line frame at 2100 cycles.
    vga_timing_gen #(
        .H_TOTAL     (4),
        .V_TOTAL     (525),
        .ANIM_DIV    (2),
        .ANIM_FRAMES (3)
    ) u_dut_b (
        .vga_clk (clk),
        .reset   (rst_b),
        .vga     (vb.master)
    );

    typedef struct {
        int          t;
        logic [24:0] exp;
    } line_vec_t;

    typedef struct {
        logic       en;
        logic [7:0] exp_frame;
        logic [7:0] exp_div;
    } anim_vec_t;

    line_vec_t lv[12];
    anim_vec_t av[14];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [24:0] pk(input int x, input int y, input logic bl,
                                       input logic h, input logic v,
                                       input logic lt, input logic ft);
        return {10'(x), 10'(y), bl, h, v, lt, ft};
    endfunction

    function automatic logic [24:0] act_a();
        return {va.DrawX, va.DrawY, va.blank, va.hs, va.vs, va.line_tick, va.frame_tick};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_b();
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b0;
    endtask

    initial begin
        int cur;
        int hs_lo, lt_cnt, vs_lo, ft_cnt, ft_t, vs_first, vs_last;

        lv[0]  = '{0,    pk(0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[1]  = '{1,    pk(1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[2]  = '{639,  pk(639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[3]  = '{640,  pk(640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[4]  = '{655,  pk(655, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[5]  = '{656,  pk(656, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        lv[6]  = '{751,  pk(751, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
        lv[7]  = '{752,  pk(752, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[8]  = '{799,  pk(799, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0)};
        lv[9]  = '{800,  pk(0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};
        lv[10] = '{1599, pk(799, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0)};
        lv[11] = '{1600, pk(0,   2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)};

        // Run 1: always enabled. Run 2: disabled during frames 2 and 3.
        av[0]  = '{1'b1, 8'd0, 8'd0};
        av[1]  = '{1'b1, 8'd0, 8'd1};
        av[2]  = '{1'b1, 8'd1, 8'd0};
        av[3]  = '{1'b1, 8'd1, 8'd1};
        av[4]  = '{1'b1, 8'd2, 8'd0};
        av[5]  = '{1'b1, 8'd2, 8'd1};
        av[6]  = '{1'b1, 8'd0, 8'd0};
        av[7]  = '{1'b1, 8'd0, 8'd0};
        av[8]  = '{1'b1, 8'd0, 8'd1};
        av[9]  = '{1'b0, 8'd1, 8'd0};
        av[10] = '{1'b0, 8'd1, 8'd0};
        av[11] = '{1'b1, 8'd1, 8'd0};
        av[12] = '{1'b1, 8'd1, 8'd1};
        av[13] = '{1'b1, 8'd2, 8'd0};

        rst_a      = 1'b1;
        rst_b      = 1'b1;
        va.anim_en = 1'b1;
        vb.anim_en = 1'b1;

        // Line timing on the full-size DUT.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset", 32'(act_a()), 32'(pk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)));
        check("in_reset_anim", 32'(va.anim_frame), 32'd0);
        rst_a = 1'b0;
        cur = 0;
        for (int i = 0; i < 12; i++) begin
            step(lv[i].t - cur);
            cur = lv[i].t;
            check($sformatf("line_vec_t%0d", lv[i].t), 32'(act_a()), 32'(lv[i].exp));
        end

        hs_lo  = 0;
        lt_cnt = 0;
        for (int k = 0; k < 800; k++) begin
            if (!va.hs)      hs_lo++;
            if (va.line_tick) lt_cnt++;
            step(1);
        end
        check("hs_low_cycles", 32'(hs_lo), 32'd96);
        check("line_tick_count", 32'(lt_cnt), 32'd1);
        check("line3_start", 32'({va.DrawX, va.DrawY}), 32'({10'd0, 10'd3}));

        // Mid-line reset during hsync: back to (0,0) with hs released on the next edge.
        step(700);
        check("pre_reset_hs", 32'(va.hs), 32'd0);
        rst_a = 1'b1;
        step(1);
        check("mid_reset", 32'(act_a()), 32'(pk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0)));
        rst_a = 1'b0;

        // Frame timing on the short-line DUT.
        reset_b();
        vs_lo    = 0;
        ft_cnt   = 0;
        ft_t     = -1;
        vs_first = -1;
        vs_last  = -1;
        for (int k = 0; k < 2100; k++) begin
            if (!vb.vs) begin
                vs_lo++;
                if (vs_first < 0) vs_first = k;
                vs_last = k;
            end
            if (vb.frame_tick) begin
                ft_cnt++;
                ft_t = k;
                check("frame_tick_pos", 32'({vb.DrawX, vb.DrawY}), 32'({10'd3, 10'd524}));
            end
            step(1);
        end
        check("vs_low_cycles", 32'(vs_lo), 32'd8);
        check("vs_first", 32'(vs_first), 32'd1960);
        check("vs_last", 32'(vs_last), 32'd1967);
        check("frame_tick_count", 32'(ft_cnt), 32'd1);
        check("frame_tick_time", 32'(ft_t), 32'd2099);
        check("frame_wrap", 32'({vb.DrawX, vb.DrawY}), 32'd0);

        // Animation runs: value at frame start and on the frame_tick cycle.
        for (int r = 0; r < 2; r++) begin
            reset_b();
            for (int f = 0; f < 7; f++) begin
                vb.anim_en = av[r*7 + f].en;
                check($sformatf("anim_r%0d_f%0d", r, f), 32'(vb.anim_frame), 32'(av[r*7 + f].exp_frame));
                check($sformatf("div_r%0d_f%0d", r, f), 32'(u_dut_b.u_anim.div_cnt_q), 32'(av[r*7 + f].exp_div));
                step(2099);
                check($sformatf("anim_hold_r%0d_f%0d", r, f), 32'(vb.anim_frame), 32'(av[r*7 + f].exp_frame));
                step(1);
            end
        end

        // Reset coincident with frame_tick while the divider is about to roll over.
        vb.anim_en = 1'b1;
        reset_b();
        step(4199);
        check("ft_before_reset", 32'(vb.frame_tick), 32'd1);
        check("div_before_reset", 32'(u_dut_b.u_anim.div_cnt_q), 32'd1);
        rst_b = 1'b1;
        step(1);
        check("anim_after_reset", 32'(vb.anim_frame), 32'd0);
        check("div_after_reset", 32'(u_dut_b.u_anim.div_cnt_q), 32'd0);
        check("pos_after_reset", 32'({vb.DrawX, vb.DrawY}), 32'd0);
        rst_b = 1'b0;
        step(1);
        check("run_after_reset", 32'({vb.DrawX, vb.DrawY}), 32'({10'd1, 10'd0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
